// File: rtl/hilo_muldiv.sv
// rtl/hilo_muldiv.sv - HI/LO register owner: single-cycle multiply, iterative restoring divide
module hilo_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       alucontrol,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic [WIDTH-1:0] result
);

  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MFHI  = 5'd20;
  localparam logic [4:0] ALU_MFLO  = 5'd21;
  localparam logic [4:0] ALU_MTHI  = 5'd22;
  localparam logic [4:0] ALU_MTLO  = 5'd23;
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {S_IDLE, S_DIV, S_DONE} state_t;

  state_t state, state_n;

  logic [WIDTH-1:0]   hi, lo;
  logic [WIDTH-1:0]   rem, quo, dvs;
  logic               neg_q, neg_r, bzero;
  logic [CW-1:0]      cnt;

  logic               issue, is_div, sgn, last;
  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic [WIDTH:0]     sh, diff;
  logic               ge;
  logic [WIDTH-1:0]   rem_n, quo_n, q_fix, r_fix;

  assign issue  = (state == S_IDLE) & start & ~flush;
  assign is_div = (alucontrol == ALU_DIV) | (alucontrol == ALU_DIVU);
  assign sgn    = (alucontrol == ALU_DIV);
  assign last   = (cnt == CW'(WIDTH - 1));

  // Full-width operands so the low 2*WIDTH product bits are the exact signed/unsigned product
  assign prod_s = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
  assign prod_u = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

  assign mag_a = (sgn & a[WIDTH-1]) ? -a : a;
  assign mag_b = (sgn & b[WIDTH-1]) ? -b : b;

  // Shifted remainder is below 2*divisor, so the WIDTH+1-bit difference keeps a valid sign bit
  assign sh    = {rem, quo[WIDTH-1]};
  assign diff  = sh - {1'b0, dvs};
  assign ge    = ~diff[WIDTH];
  assign rem_n = ge ? diff[WIDTH-1:0] : sh[WIDTH-1:0];
  assign quo_n = {quo[WIDTH-2:0], ge};
  assign q_fix = bzero ? '1 : (neg_q ? -quo_n : quo_n);
  assign r_fix = neg_r ? -rem_n : rem_n;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE:  if (issue && is_div) state_n = S_DIV;
      S_DIV:   if (flush) state_n = S_IDLE;
               else if (last) state_n = S_DONE;
      S_DONE:  state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    stall = 1'b0;
    done  = 1'b0;
    case (state)
      S_IDLE:  stall = issue & is_div;
      S_DIV:   stall = 1'b1;
      S_DONE:  done  = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hi    <= '0;
      lo    <= '0;
      rem   <= '0;
      quo   <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
      bzero <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (issue) begin
            case (alucontrol)
              ALU_MULT:  {hi, lo} <= prod_s;
              ALU_MULTU: {hi, lo} <= prod_u;
              ALU_MTHI:  hi <= a;
              ALU_MTLO:  lo <= a;
              ALU_DIV, ALU_DIVU: begin
                rem   <= '0;
                quo   <= mag_a;
                dvs   <= mag_b;
                neg_q <= sgn & (a[WIDTH-1] ^ b[WIDTH-1]);
                neg_r <= sgn & a[WIDTH-1];
                bzero <= (b == '0);
                cnt   <= '0;
              end
              default: ;
            endcase
          end
        end
        S_DIV: begin
          if (!flush) begin
            rem <= rem_n;
            quo <= quo_n;
            cnt <= cnt + 1'b1;
            if (last) begin
              hi <= r_fix;
              lo <= q_fix;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o   = hi;
  assign lo_o   = lo;
  assign result = (alucontrol == ALU_MFHI) ? hi :
                  (alucontrol == ALU_MFLO) ? lo : '0;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb/tb_hilo_muldiv.sv - randomized self-checking bench for hilo_muldiv against an arithmetic model
module tb_hilo_muldiv;

  localparam logic [4:0] ALU_MULT  = 5'd16;
  localparam logic [4:0] ALU_MULTU = 5'd17;
  localparam logic [4:0] ALU_DIV   = 5'd18;
  localparam logic [4:0] ALU_DIVU  = 5'd19;
  localparam logic [4:0] ALU_MFHI  = 5'd20;
  localparam logic [4:0] ALU_MFLO  = 5'd21;
  localparam logic [4:0] ALU_MTHI  = 5'd22;
  localparam logic [4:0] ALU_MTLO  = 5'd23;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [4:0]  alucontrol = 5'd0;
  logic [31:0] op_a = '0, op_b = '0;
  logic        flush = 1'b0;
  logic        stall, done;
  logic [31:0] hi_o, lo_o, result;

  logic [31:0] exp_hi = '0, exp_lo = '0;
  logic        exp_stall = 1'b0, exp_done = 1'b0;
  logic        cmp_en = 1'b1;
  int          errors = 0, checks = 0;
  int          stall_cycles = 0, done_pulses = 0;

  hilo_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .alucontrol(alucontrol),
    .a(op_a), .b(op_b), .flush(flush), .stall(stall), .done(done),
    .hi_o(hi_o), .lo_o(lo_o), .result(result)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic logic [63:0] mul_model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    longint p;
    if (sgn) begin
      p = longint'($signed(x)) * longint'($signed(y));
      return p;
    end
    return {32'b0, x} * {32'b0, y};
  endfunction

  // Returns {HI, LO}; 64-bit signed arithmetic sidesteps the most-negative / -1 overflow
  function automatic logic [63:0] div_model(input logic sgn, input logic [31:0] x, input logic [31:0] y);
    longint sa, sb, q, r;
    if (y == 0) return {x, 32'hFFFF_FFFF};
    if (sgn) begin
      sa = longint'($signed(x));
      sb = longint'($signed(y));
      q  = sa / sb;
      r  = sa % sb;
      return {r[31:0], q[31:0]};
    end
    return {x % y, x / y};
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("stall", 32'(stall), 32'(exp_stall));
      chk("done", 32'(done), 32'(exp_done));
      chk("hi_o", hi_o, exp_hi);
      chk("lo_o", lo_o, exp_lo);
      chk("result", result, (alucontrol == ALU_MFHI) ? exp_hi :
                            (alucontrol == ALU_MFLO) ? exp_lo : 32'h0);
      if (stall) stall_cycles++;
      if (done) done_pulses++;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_simple(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y, input logic fl);
    start = 1'b1; alucontrol = op; op_a = x; op_b = y; flush = fl;
    exp_stall = 1'b0; exp_done = 1'b0;
    step();
    if (!fl) begin
      case (op)
        ALU_MULT:  {exp_hi, exp_lo} = mul_model(1'b1, x, y);
        ALU_MULTU: {exp_hi, exp_lo} = mul_model(1'b0, x, y);
        ALU_MTHI:  exp_hi = x;
        ALU_MTLO:  exp_lo = x;
        default: ;
      endcase
    end
    start = 1'b0; flush = 1'b0; alucontrol = 5'd0;
  endtask

  task automatic do_div(input logic [4:0] op, input logic [31:0] x, input logic [31:0] y,
                        input int flush_at, input int rst_at);
    start = 1'b1; alucontrol = op; op_a = x; op_b = y; flush = 1'b0;
    exp_stall = 1'b1; exp_done = 1'b0;
    step();
    for (int k = 0; k < 32; k++) begin
      op_a = $urandom; op_b = $urandom; alucontrol = 5'($urandom_range(0, 31));
      if (k == rst_at) begin
        rst = 1'b1; start = 1'b0; alucontrol = 5'd0;
        exp_hi = '0; exp_lo = '0; exp_stall = 1'b0;
        #1;
        chk("rst_hi", hi_o, 32'h0);
        chk("rst_lo", lo_o, 32'h0);
        chk("rst_stall", 32'(stall), 32'h0);
        step();
        rst = 1'b0;
        return;
      end
      if (k == flush_at) flush = 1'b1;
      step();
      if (k == flush_at) begin
        flush = 1'b0; start = 1'b0; alucontrol = 5'd0; exp_stall = 1'b0;
        return;
      end
    end
    {exp_hi, exp_lo} = div_model(op == ALU_DIV, x, y);
    exp_stall = 1'b0; exp_done = 1'b1;
    alucontrol = op; op_a = x; op_b = y; flush = 1'(($urandom_range(0, 1)));
    step();
    exp_done = 1'b0; start = 1'b0; flush = 1'b0; alucontrol = 5'd0;
  endtask

  function automatic logic [31:0] rnd32();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [4:0] ops [8];
    ops = '{ALU_MULT, ALU_MULTU, ALU_DIV, ALU_DIVU, ALU_MFHI, ALU_MFLO, ALU_MTHI, ALU_MTLO};

    repeat (3) step();
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_done", 32'(done), 32'h0);
    rst = 1'b0;
    step();

    stall_cycles = 0;
    do_simple(ALU_MULT, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("mult_hi", hi_o, 32'hFFFF_FFFF);
    chk("mult_lo", lo_o, 32'hFFFF_FFFA);
    do_simple(ALU_MFHI, 32'h0, 32'h0, 1'b0);
    do_simple(ALU_MFLO, 32'h0, 32'h0, 1'b0);
    do_simple(ALU_MULTU, 32'hFFFF_FFFE, 32'd3, 1'b0);
    chk("multu_hi", hi_o, 32'h0000_0002);
    chk("multu_lo", lo_o, 32'hFFFF_FFFA);
    chk("mult_nostall", 32'(stall_cycles), 32'h0);

    stall_cycles = 0; done_pulses = 0;
    do_div(ALU_DIVU, 32'd100, 32'd7, -1, -1);
    chk("divu_stalls", 32'(stall_cycles), 32'd33);
    chk("divu_done", 32'(done_pulses), 32'd1);
    chk("divu_lo", lo_o, 32'd14);
    chk("divu_hi", hi_o, 32'd2);

    do_div(ALU_DIV, 32'hFFFF_FFF9, 32'd2, -1, -1);
    chk("div_neg_lo", lo_o, 32'hFFFF_FFFD);
    chk("div_neg_hi", hi_o, 32'hFFFF_FFFF);
    do_div(ALU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1);
    chk("div_ovf_lo", lo_o, 32'h8000_0000);
    chk("div_ovf_hi", hi_o, 32'h0);

    stall_cycles = 0;
    do_div(ALU_DIV, 32'd5, 32'd0, -1, -1);
    chk("div0_stalls", 32'(stall_cycles), 32'd33);
    chk("div0_lo", lo_o, 32'hFFFF_FFFF);
    chk("div0_hi", hi_o, 32'd5);

    do_simple(ALU_MTHI, 32'h1234_5678, 32'h0, 1'b0);
    do_simple(ALU_MTLO, 32'h9ABC_DEF0, 32'h0, 1'b0);
    done_pulses = 0;
    do_div(ALU_DIVU, 32'd1000, 32'd3, 5, -1);
    chk("flush_hi", hi_o, 32'h1234_5678);
    chk("flush_lo", lo_o, 32'h9ABC_DEF0);
    chk("flush_done", 32'(done_pulses), 32'h0);
    start = 1'b1; alucontrol = ALU_MFLO;
    #1;
    chk("flush_mflo", result, 32'h9ABC_DEF0);
    step();
    start = 1'b0; alucontrol = 5'd0;

    do_simple(ALU_MULT, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 1'b0);
    do_div(ALU_DIV, 32'd12345, 32'd17, -1, 10);

    for (int n = 0; n < 60; n++) begin
      int sel;
      logic [31:0] x, y;
      logic fl;
      sel = $urandom_range(0, 9);
      x = rnd32(); y = rnd32();
      fl = ($urandom_range(0, 9) == 0);
      if (sel == 9) begin
        start = 1'b0; step();
      end else if (sel == 8) begin
        do_simple(5'($urandom_range(0, 15)), x, y, fl);
      end else if ((ops[sel] == ALU_DIV || ops[sel] == ALU_DIVU) && !fl) begin
        do_div(ops[sel], x, y, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : -1, -1);
      end else begin
        do_simple(ops[sel], x, y, fl);
      end
    end

    step();
    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
